mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - four-core round-robin arbiter for one shared synchronous RAM
//
// Purpose: grants one core at a time a fixed three-cycle access
// (IDLE -> ISSUE -> RESP) to a RAM whose read data arrives one cycle after
// mem_en. It also tracks per-core end-of-program reports and counts cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req[3:0], we[3:0]         per-core request / write enable
//   addr_flat, wdata_flat     per-core address and write data, packed
//   mem_rdata                 RAM read data, valid one cycle after mem_en
//   core_done[3:0]            per-core end-of-program indication
//   gnt[3:0], ack[3:0]        one-hot grant, one-cycle completion pulse
//   rdata                     read data, valid while ack is high for a read
//   mem_en, mem_we            RAM enable and write strobe
//   mem_addr, mem_wdata       RAM address and write data
//   all_done                  sticky, every core has reported done
//   cycle_count               cycles since reset release, frozen by all_done
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [3:0]          we,
  input  logic [4*ADDR_W-1:0] addr_flat,
  input  logic [4*DATA_W-1:0] wdata_flat,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [3:0]          core_done,
  output logic [3:0]          gnt,
  output logic [3:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                all_done,
  output logic [31:0]         cycle_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        win_q, win_d;
  logic              acc_we_q, acc_we_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [3:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        done_seen_q, done_seen_d;
  logic              all_done_q, all_done_d;
  logic [31:0]       cnt_q, cnt_d;

  // A core whose ack is high this cycle may still be holding req; masking it
  // keeps that core from being served a second time.
  logic [3:0] elig;
  logic       rr_found;
  logic [1:0] rr_win;
  logic [1:0] rr_idx;

  always_comb begin
    elig     = req & ~ack_q;
    rr_found = 1'b0;
    rr_win   = ptr_q;
    rr_idx   = '0;
    // Search ptr+1, ptr+2, ptr+3, ptr; the 2-bit add wraps mod 4.
    for (int k = 1; k <= 4; k++) begin
      rr_idx = ptr_q + 2'(k);
      if (!rr_found && elig[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    acc_we_d    = acc_we_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          state_d     = ST_ISSUE;
          win_d       = rr_win;
          gnt_d       = 4'b0001 << rr_win;
          mem_en_d    = 1'b1;
          mem_we_d    = we[rr_win];
          acc_we_d    = we[rr_win];
          mem_addr_d  = addr_flat[int'(rr_win)*ADDR_W +: ADDR_W];
          mem_wdata_d = wdata_flat[int'(rr_win)*DATA_W +: DATA_W];
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // RAM data for the ISSUE-cycle read is valid now.
        state_d = ST_IDLE;
        ack_d   = gnt_q;
        gnt_d   = '0;
        ptr_d   = win_q;
        if (!acc_we_q) begin
          rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    done_seen_d = done_seen_q | core_done;
    all_done_d  = all_done_q | (&done_seen_q);
    cnt_d       = cnt_q;
    if (!all_done_q && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd3;
      win_q       <= 2'd0;
      acc_we_q    <= 1'b0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_seen_q <= '0;
      all_done_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      acc_we_q    <= acc_we_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_seen_q <= done_seen_d;
      all_done_q  <= all_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign all_done    = all_done_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic                clk;
  logic                rst;
  logic [3:0]          req;
  logic [3:0]          we;
  logic [4*ADDR_W-1:0] addr_flat;
  logic [4*DATA_W-1:0] wdata_flat;
  logic [DATA_W-1:0]   mem_rdata;
  logic [3:0]          core_done;
  logic [3:0]          gnt;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                all_done;
  logic [31:0]         cycle_count;

  int tests_run;
  int tests_failed;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr_flat(addr_flat), .wdata_flat(wdata_flat),
    .mem_rdata(mem_rdata), .core_done(core_done),
    .gnt(gnt), .ack(ack), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .all_done(all_done), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we = '0; core_done = '0;
    addr_flat = '0; wdata_flat = '0; mem_rdata = '0;
    tick();
    tick();
    tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    tests_run++; if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    tests_run++; if (all_done !== 1'b0) begin tests_failed++; $display("FAIL reset_all_done: got %b expected 0", all_done); end
    tests_run++; if (cycle_count !== 32'd0) begin tests_failed++; $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
    tests_run++; if (rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    req = 4'b0100; we = 4'b0000;
    addr_flat[2*ADDR_W +: ADDR_W] = 16'h0010;
    mem_rdata = 8'hAB;
    tick();
    tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL read_gnt: got %b expected 0100", gnt); end
    tests_run++; if (mem_en !== 1'b1) begin tests_failed++; $display("FAIL read_mem_en: got %b expected 1", mem_en); end
    tests_run++; if (mem_addr !== 16'h0010) begin tests_failed++; $display("FAIL read_mem_addr: got %h expected 0010", mem_addr); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL read_mem_we: got %b expected 0", mem_we); end
    tick();
    tests_run++; if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL read_mem_en_drop: got %b expected 0", mem_en); end
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL read_ack_early: got %b expected 0000", ack); end
    tick();
    tests_run++; if (ack !== 4'b0100) begin tests_failed++; $display("FAIL read_ack: got %b expected 0100", ack); end
    tests_run++; if (rdata !== 8'hAB) begin tests_failed++; $display("FAIL read_rdata: got %h expected AB", rdata); end
    tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL read_gnt_clear: got %b expected 0000", gnt); end
    // Core keeps req high during the ack cycle; it must not be re-granted.
    tick();
    tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL read_no_double: got %b expected 0000", gnt); end
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL read_ack_pulse: got %b expected 0000", ack); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_write();
    req = 4'b0010; we = 4'b0010;
    addr_flat[1*ADDR_W +: ADDR_W] = 16'h0003;
    wdata_flat[1*DATA_W +: DATA_W] = 8'h55;
    mem_rdata = 8'h77;
    tick();
    tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL write_gnt: got %b expected 0010", gnt); end
    tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL write_mem_we: got %b expected 1", mem_we); end
    tests_run++; if (mem_wdata !== 8'h55) begin tests_failed++; $display("FAIL write_mem_wdata: got %h expected 55", mem_wdata); end
    tests_run++; if (mem_addr !== 16'h0003) begin tests_failed++; $display("FAIL write_mem_addr: got %h expected 0003", mem_addr); end
    // Inputs changing after the grant edge must not disturb the access.
    we = 4'b0000;
    addr_flat[1*ADDR_W +: ADDR_W] = 16'hFFFF;
    wdata_flat[1*DATA_W +: DATA_W] = 8'h99;
    tick();
    tests_run++; if (mem_addr !== 16'h0003) begin tests_failed++; $display("FAIL write_addr_hold: got %h expected 0003", mem_addr); end
    tests_run++; if (mem_wdata !== 8'h55) begin tests_failed++; $display("FAIL write_wdata_hold: got %h expected 55", mem_wdata); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL write_we_drop: got %b expected 0", mem_we); end
    tick();
    tests_run++; if (ack !== 4'b0010) begin tests_failed++; $display("FAIL write_ack: got %b expected 0010", ack); end
    tests_run++; if (rdata !== 8'hAB) begin tests_failed++; $display("FAIL write_rdata_keep: got %h expected AB", rdata); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    rst = 1'b1;
    req = 4'b1111; we = 4'b0000;
    tick();
    tick();
    tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL cont_no_sample_in_rst: got %b expected 0000", gnt); end
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      exp = 4'b0001 << (n % 4);
      tick();
      tests_run++; if (gnt !== exp) begin tests_failed++; $display("FAIL cont_gnt_%0d: got %b expected %b", n, gnt, exp); end
      tick();
      tests_run++; if ($countones(gnt) > 1) begin tests_failed++; $display("FAIL cont_onehot_%0d: got %b expected at most one bit", n, gnt); end
      tick();
      tests_run++; if (ack !== exp) begin tests_failed++; $display("FAIL cont_ack_%0d: got %b expected %b", n, ack, exp); end
    end
    req = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1010; we = 4'b0000;
    tick();
    tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL rmid_gnt: got %b expected 0010", gnt); end
    rst = 1'b1;
    req = 4'b1111;
    tick();
    tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL rmid_gnt_clear: got %b expected 0000", gnt); end
    tests_run++; if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL rmid_mem_en: got %b expected 0", mem_en); end
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL rmid_ack: got %b expected 0000", ack); end
    rst = 1'b0;
    tick();
    tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL rmid_core0_first: got %b expected 0001", gnt); end
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL rmid_no_stale_ack: got %b expected 0000", ack); end
    tick();
    tick();
    tests_run++; if (ack !== 4'b0001) begin tests_failed++; $display("FAIL rmid_ack_core0: got %b expected 0001", ack); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_done();
    logic [31:0] exp_cnt;
    logic        exp_done;
    do_reset();
    // Cycle c is the cycle during which cycle_count reads c; a pulse driven
    // there is seen at the next edge. The last pulse (c=20) completes
    // done_seen at edge 21, all_done rises at edge 22, count freezes at 22.
    for (int c = 0; c <= 30; c++) begin
      exp_cnt  = (c <= 22) ? 32'(c) : 32'd22;
      exp_done = (c >= 22);
      tests_run++; if (cycle_count !== exp_cnt) begin tests_failed++; $display("FAIL done_count_c%0d: got %0d expected %0d", c, cycle_count, exp_cnt); end
      tests_run++; if (all_done !== exp_done) begin tests_failed++; $display("FAIL done_flag_c%0d: got %b expected %b", c, all_done, exp_done); end
      case (c)
        5:  core_done = 4'b1000;
        9:  core_done = 4'b0001;
        14: core_done = 4'b0100;
        20: core_done = 4'b0010;
        default: core_done = 4'b0000;
      endcase
      tick();
    end
    core_done = 4'b0000;
    // Arbitration keeps working after all_done.
    req = 4'b1000; we = 4'b0000;
    tick();
    tests_run++; if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL done_arb_continues: got %b expected 1000", gnt); end
    tick();
    tick();
    tests_run++; if (ack !== 4'b1000) begin tests_failed++; $display("FAIL done_arb_ack: got %b expected 1000", ack); end
    tests_run++; if (cycle_count !== 32'd22) begin tests_failed++; $display("FAIL done_count_frozen: got %0d expected 22", cycle_count); end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; req = '0; we = '0; core_done = '0;
    addr_flat = '0; wdata_flat = '0; mem_rdata = '0;
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_reset_mid();
    test_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
